// File: rtl/trace_pkg.sv
// Shared types for the write-back trace checker: the golden trace entry
// layout, the checker state encoding and the error counter width.
package trace_pkg;

    localparam int ERR_CNT_W = 16;

    // One golden write-back record, compared field by field against a commit
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } chk_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of golden trace entries. Pointers carry one extra wrap
// bit so full and empty are told apart without an occupancy counter.
// A push and a pop in the same cycle both take effect.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  trace_entry_t i_data,
    input  logic         i_pop,
    output trace_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    trace_entry_t r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Advance read/write pointers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares CPU write-back commits against a golden trace streamed in through
// a small FIFO, counts matches/errors, captures the first mismatch and gives
// a pass/fail verdict once the run reaches END_PC.
// Optional build macro TRACE_MISMATCH_HALT_EN: the first error stops the run
// in the ERROR state with fail asserted and all statistics frozen.
module wb_trace_checker
    import trace_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] END_PC     = 32'h1c000100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          debug_wb_pc,
    input  logic [3:0]           debug_wb_rf_we,
    input  logic [4:0]           debug_wb_rf_wnum,
    input  logic [31:0]          debug_wb_rf_wdata,
    input  logic                 gold_valid,
    output logic                 gold_ready,
    input  logic [31:0]          gold_pc,
    input  logic [4:0]           gold_wnum,
    input  logic [31:0]          gold_wdata,
    output logic                 pass,
    output logic                 fail,
    output logic [31:0]          match_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          err_pc,
    output logic [31:0]          err_exp_wdata,
    output logic [31:0]          err_got_wdata
);

    chk_state_t           r_state;
    logic                 r_pass;
    logic                 r_fail;
    logic [31:0]          r_match_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [31:0]          r_err_pc;
    logic [31:0]          r_err_exp_wdata;
    logic [31:0]          r_err_got_wdata;

    trace_entry_t         w_gold_in;
    trace_entry_t         w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_active;
    logic                 w_commit;
    logic                 w_push;
    logic                 w_chk;
    logic                 w_pop;
    logic                 w_fields_eq;
    logic                 w_match;
    logic                 w_err;
    logic                 w_halt_err;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

    assign w_gold_in   = '{pc: gold_pc, wnum: gold_wnum, wdata: gold_wdata};

    // Writes to r0 or with no enable are not architectural commits
    assign w_commit    = (debug_wb_rf_we != 4'b0) && (debug_wb_rf_wnum != 5'd0);
    assign w_active    = (r_state == IDLE) || (r_state == RUN);

    // Ready depends only on registered state, so a full FIFO never accepts
    // a push even when a pop happens in the same cycle
    assign gold_ready  = !w_full && w_active;
    assign w_push      = gold_valid && gold_ready;

    assign w_chk       = w_active && w_commit;
    assign w_pop       = w_chk && !w_empty;
    assign w_fields_eq = (w_head.pc == debug_wb_pc) &&
                         (w_head.wnum == debug_wb_rf_wnum) &&
                         (w_head.wdata == debug_wb_rf_wdata);
    assign w_match     = w_pop && w_fields_eq;
    assign w_err       = w_chk && (w_empty || !w_fields_eq);

    // Saturating error count, needed ahead of the edge to form the verdict
    assign w_err_cnt_nxt = (w_err && (r_err_cnt != '1)) ? r_err_cnt + ERR_CNT_W'(1)
                                                        : r_err_cnt;

`ifdef TRACE_MISMATCH_HALT_EN
    assign w_halt_err = w_err;
`else
    assign w_halt_err = 1'b0;
`endif

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_gold_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Run-state FSM together with statistics, first-error capture and verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_pass          <= 1'b0;
            r_fail          <= 1'b0;
            r_match_cnt     <= '0;
            r_err_cnt       <= '0;
            r_err_pc        <= '0;
            r_err_exp_wdata <= '0;
            r_err_got_wdata <= '0;
        end else begin
            if (w_match) r_match_cnt <= r_match_cnt + 32'd1;
            r_err_cnt <= w_err_cnt_nxt;

            // Only the first mismatch is captured; the counter never wraps to 0
            if (w_err && (r_err_cnt == '0)) begin
                r_err_pc        <= debug_wb_pc;
                r_err_got_wdata <= debug_wb_rf_wdata;
                r_err_exp_wdata <= w_empty ? 32'h0 : w_head.wdata;
            end

            case (r_state)
                IDLE: begin
                    if (w_halt_err) begin
                        r_state <= ERROR;
                        r_fail  <= 1'b1;
                    end else if (w_push || w_commit) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_halt_err) begin
                        r_state <= ERROR;
                        r_fail  <= 1'b1;
                    end else if (debug_wb_pc == END_PC) begin
                        // The END_PC commit itself is already folded into w_err_cnt_nxt
                        r_state <= DONE;
                        r_pass  <= (w_err_cnt_nxt == '0);
                        r_fail  <= (w_err_cnt_nxt != '0);
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign pass          = r_pass;
    assign fail          = r_fail;
    assign match_cnt     = r_match_cnt;
    assign err_cnt       = r_err_cnt;
    assign err_pc        = r_err_pc;
    assign err_exp_wdata = r_err_exp_wdata;
    assign err_got_wdata = r_err_got_wdata;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Scoreboard bench for wb_trace_checker: a behavioural model predicts the
// outputs for each driven cycle, pushes them to a queue, and they are popped
// and compared one clock later.
module tb_wb_trace_checker;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] END_PC = 32'h1c000100;

    logic        clk;
    logic        reset;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_pc;
    logic [4:0]  gold_wnum;
    logic [31:0] gold_wdata;
    logic        pass;
    logic        fail;
    logic [31:0] match_cnt;
    logic [15:0] err_cnt;
    logic [31:0] err_pc;
    logic [31:0] err_exp_wdata;
    logic [31:0] err_got_wdata;

    wb_trace_checker #(
        .FIFO_DEPTH (DEPTH),
        .END_PC     (END_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .gold_valid        (gold_valid),
        .gold_ready        (gold_ready),
        .gold_pc           (gold_pc),
        .gold_wnum         (gold_wnum),
        .gold_wdata        (gold_wdata),
        .pass              (pass),
        .fail              (fail),
        .match_cnt         (match_cnt),
        .err_cnt           (err_cnt),
        .err_pc            (err_pc),
        .err_exp_wdata     (err_exp_wdata),
        .err_got_wdata     (err_got_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } ent_t;

    typedef struct {
        logic [31:0] match;
        logic [15:0] err;
        logic [31:0] epc;
        logic [31:0] eexp;
        logic [31:0] egot;
        logic        pass;
        logic        fail;
    } want_t;

    ent_t        m_q[$];
    want_t       sb[$];
    int          m_state;   // 0 IDLE, 1 RUN, 2 DONE, 3 ERROR
    logic [31:0] m_match;
    logic [15:0] m_err;
    logic [31:0] m_epc;
    logic [31:0] m_eexp;
    logic [31:0] m_egot;
    bit          m_halt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        sb.delete();
        m_state = 0;
        m_match = '0;
        m_err   = '0;
        m_epc   = '0;
        m_eexp  = '0;
        m_egot  = '0;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        gold_valid        = 1'b0;
        gold_pc           = '0;
        gold_wnum         = '0;
        gold_wdata        = '0;
        debug_wb_pc       = '0;
        debug_wb_rf_we    = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_match", match_cnt, 32'h0);
        chk("rst_err", {16'h0, err_cnt}, 32'h0);
        chk("rst_epc", err_pc, 32'h0);
        chk("rst_eexp", err_exp_wdata, 32'h0);
        chk("rst_egot", err_got_wdata, 32'h0);
        chk("rst_pass", {31'h0, pass}, 32'h0);
        chk("rst_fail", {31'h0, fail}, 32'h0);
        chk("rst_ready", {31'h0, gold_ready}, 32'h1);
    endtask

    // Drive one cycle of stimulus, predict its effect, compare after the edge
    task automatic cycle(input logic gv, input logic [31:0] gpc, input logic [4:0] gwn,
                         input logic [31:0] gwd, input logic [3:0] we,
                         input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        bit    active, ready, commit, push, err;
        ent_t  h;
        ent_t  ne;
        want_t w;
        want_t g;
        gold_valid        = gv;
        gold_pc           = gpc;
        gold_wnum         = gwn;
        gold_wdata        = gwd;
        debug_wb_rf_we    = we;
        debug_wb_pc       = pc;
        debug_wb_rf_wnum  = wn;
        debug_wb_rf_wdata = wd;
        #1;
        active = (m_state == 0) || (m_state == 1);
        ready  = active && (m_q.size() < DEPTH);
        commit = (we != 4'h0) && (wn != 5'd0);
        push   = gv && ready;
        err    = 1'b0;
        chk("gold_ready", {31'h0, gold_ready}, {31'h0, ready});
        if (active && commit) begin
            if (m_q.size() > 0) begin
                h = m_q.pop_front();
                if (h.pc == pc && h.wnum == wn && h.wdata == wd) m_match = m_match + 1;
                else begin
                    err = 1'b1;
                    if (m_err == 0) m_eexp = h.wdata;
                end
            end else begin
                err = 1'b1;
                if (m_err == 0) m_eexp = 32'h0;
            end
        end
        if (err) begin
            if (m_err == 0) begin
                m_epc  = pc;
                m_egot = wd;
            end
            if (m_err != 16'hFFFF) m_err = m_err + 1;
        end
        if (push) begin
            ne.pc = gpc; ne.wnum = gwn; ne.wdata = gwd;
            m_q.push_back(ne);
        end
        if (m_state == 0) begin
            if (m_halt && err) m_state = 3;
            else if (push || commit) m_state = 1;
        end else if (m_state == 1) begin
            if (m_halt && err) m_state = 3;
            else if (pc == END_PC) m_state = 2;
        end
        w.match = m_match;
        w.err   = m_err;
        w.epc   = m_epc;
        w.eexp  = m_eexp;
        w.egot  = m_egot;
        w.pass  = (m_state == 2) && (m_err == 0);
        w.fail  = ((m_state == 2) && (m_err != 0)) || (m_state == 3);
        sb.push_back(w);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("match_cnt", match_cnt, g.match);
        chk("err_cnt", {16'h0, err_cnt}, {16'h0, g.err});
        chk("err_pc", err_pc, g.epc);
        chk("err_exp", err_exp_wdata, g.eexp);
        chk("err_got", err_got_wdata, g.egot);
        chk("pass", {31'h0, pass}, {31'h0, g.pass});
        chk("fail", {31'h0, fail}, {31'h0, g.fail});
        chk("exclusive", {31'h0, pass & fail}, 32'h0);
    endtask

    task automatic push_gold(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        cycle(1'b1, pc, wn, wd, 4'h0, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        cycle(1'b0, 32'h0, 5'd0, 32'h0, 4'hF, pc, wn, wd);
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 32'h0, 5'd0, 32'h0);
    endtask

    initial begin
`ifdef TRACE_MISMATCH_HALT_EN
        m_halt = 1'b1;
`else
        m_halt = 1'b0;
`endif
        do_reset();

        // Three matching commits
        push_gold(32'h1c000000, 5'd1, 32'h5);
        push_gold(32'h1c000004, 5'd2, 32'h7);
        push_gold(32'h1c000008, 5'd3, 32'hc);
        commit(32'h1c000000, 5'd1, 32'h5);
        commit(32'h1c000004, 5'd2, 32'h7);
        commit(32'h1c000008, 5'd3, 32'hc);
        chk("three_match", match_cnt, 32'd3);

        // Non-commit cycles (r0 write, no enable) must not pop
        push_gold(32'h1c000010, 5'd4, 32'h44);
        commit(32'h1c000010, 5'd0, 32'h44);
        cycle(1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 32'h1c000010, 5'd4, 32'h44);
        idle();
        commit(32'h1c000010, 5'd4, 32'h44);

        // wdata mismatch, later matches and a second error leave capture alone
        push_gold(32'h1c000004, 5'd2, 32'h7);
        commit(32'h1c000004, 5'd2, 32'h8);
        idle();
        push_gold(32'h1c000014, 5'd5, 32'h55);
        commit(32'h1c000014, 5'd5, 32'h55);
        push_gold(32'h1c000018, 5'd6, 32'h66);
        commit(32'h1c000018, 5'd7, 32'h66);
        // END_PC commit on an empty FIFO ends the run with a fail verdict
        commit(END_PC, 5'd1, 32'h1);
        idle();
        commit(32'h1c000020, 5'd1, 32'h1);

        // Underflow from reset: error counted, expected data 0, nothing popped
        do_reset();
        commit(32'h1c000020, 5'd6, 32'h66);
        push_gold(32'h1c000024, 5'd7, 32'h77);
        commit(32'h1c000024, 5'd7, 32'h77);

        // Fill to capacity, then simultaneous push/pop at 7 entries
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            push_gold(32'h1c000200 + 32'(i * 4), 5'(i + 1), 32'(i * 3 + 1));
        push_gold(32'h1c000300, 5'd9, 32'h99);
        commit(32'h1c000200, 5'd1, 32'h1);
        cycle(1'b1, 32'h1c000304, 5'd10, 32'haa, 4'hF, 32'h1c000204, 5'd2, 32'h4);
        push_gold(32'h1c000308, 5'd11, 32'hbb);
        push_gold(32'h1c00030c, 5'd12, 32'hcc);
        for (int i = 0; i < 2 * DEPTH && m_q.size() > 0; i++)
            commit(m_q[0].pc, m_q[0].wnum, m_q[0].wdata);

        // Clean run to END_PC, then further traffic is ignored
        do_reset();
        push_gold(32'h1c0000fc, 5'd3, 32'h30);
        push_gold(END_PC, 5'd4, 32'h40);
        commit(32'h1c0000fc, 5'd3, 32'h30);
        commit(END_PC, 5'd4, 32'h40);
        push_gold(32'h1c000104, 5'd5, 32'h50);
        commit(32'h1c000104, 5'd5, 32'h51);
        idle();

        // Reset in the middle of a run with an error captured
        do_reset();
        push_gold(32'h1c000040, 5'd8, 32'h80);
        push_gold(32'h1c000044, 5'd9, 32'h90);
        commit(32'h1c000040, 5'd8, 32'h81);
        do_reset();
        commit(32'h1c000044, 5'd9, 32'h90);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
